decoder_scan_ctrl: RTL and testbench

- Sequential channel scanner that drives the select inputs (x, y, z) of the 3-to-8 line decoder directly downstream of it.
- Steps through the eight channels in ascending order, skipping masked-off channels.
- Holds each channel for a programmable dwell time, then inserts a one-cycle blank (sel_valid low) between channels to prevent ghosting on multiplexed loads.
- Supports continuous and one-shot frame modes, with a frame-complete pulse.

---
 rtl/decoder_scan_ctrl_pkg.sv | 16 +
 rtl/decoder_scan_ctrl_if.sv | 34 +++
 rtl/decoder_scan_ctrl_find_next_ch.sv | 46 ++++
 rtl/decoder_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/decoder_scan_ctrl_pkg.sv
// decoder_scan_ctrl_pkg
//   Shared constants and the FSM state type for the decoder channel scanner.
//   NUM_CH : number of decoder channels scanned (3-to-8 decoder downstream)
//   SEL_W  : width of the channel select index
package decoder_scan_ctrl_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// decoder_scan_ctrl_if
//   Control/status bundle between a scan controller and its host.
//   Host -> scanner : start, stop, one_shot, dwell[DWELL_W], ch_mask[NUM_CH]
//   Scanner -> host : sel_x/sel_y/sel_z (decoder select, x = LSB), sel_valid,
//                     frame_done (1-cycle pulse), busy
//   modport master : host side, modport slave : scanner side
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  import decoder_scan_ctrl_pkg::*;

  logic               start;
  logic               stop;
  logic               one_shot;
  logic [DWELL_W-1:0] dwell;
  logic [NUM_CH-1:0]  ch_mask;
  logic               sel_x;
  logic               sel_y;
  logic               sel_z;
  logic               sel_valid;
  logic               frame_done;
  logic               busy;

  modport master (
    output start, stop, one_shot, dwell, ch_mask,
    input  sel_x, sel_y, sel_z, sel_valid, frame_done, busy
  );

  modport slave (
    input  start, stop, one_shot, dwell, ch_mask,
    output sel_x, sel_y, sel_z, sel_valid, frame_done, busy
  );

endinterface

// File: rtl/decoder_scan_ctrl_find_next_ch.sv
// find_next_ch
//   Combinational search for the next enabled channel.
//   mask       : per-channel enable
//   cur        : current channel index
//   from_start : 1 = lowest enabled index (inclusive search from 0),
//                0 = first enabled index strictly above cur, wrapping
//   nxt        : resulting channel index (cur when nothing is enabled)
//   wrap       : search passed index 7 (includes returning to cur itself)
//   none       : mask has no enabled channel
module find_next_ch
  import decoder_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              from_start,
  output logic [SEL_W-1:0]  nxt,
  output logic              wrap,
  output logic              none
);

  logic [SEL_W:0] base_s;
  logic [SEL_W:0] cand_s;
  logic           found_s;

  // Priority scan over eight candidates; the extra MSB of the candidate
  // index records that the search ran past channel 7.
  always_comb begin
    base_s  = from_start ? 4'd0 : ({1'b0, cur} + 4'd1);
    cand_s  = base_s;
    nxt     = cur;
    wrap    = 1'b0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = base_s + 4'(k);
      if (!found_s && mask[cand_s[SEL_W-1:0]]) begin
        found_s = 1'b1;
        nxt     = cand_s[SEL_W-1:0];
        wrap    = cand_s[SEL_W];
      end else begin
        found_s = found_s;
      end
    end
    none = (mask == 8'h00);
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Sequential channel scanner driving the x/y/z selects of a 3-to-8 decoder.
//   Visits enabled channels in ascending order, holds each for dwell+1
//   cycles, then blanks sel_valid for one cycle. Continuous or one-shot
//   frames; frame_done pulses in the blank that wraps past channel 7.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of decoder_scan_ctrl_if (controls in, selects out)
module decoder_scan_ctrl
  import decoder_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 8
)
(
  input  logic                clk,
  input  logic                rst_n,
  decoder_scan_ctrl_if.slave  bus
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [DWELL_W-1:0] cnt_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [NUM_CH-1:0]  mask_r;
  logic               one_shot_r;
  logic [SEL_W-1:0]   sel_r;
  logic               sel_valid_r;
  logic               frame_done_r;
  logic               busy_r;

  logic [NUM_CH-1:0]  search_mask_s;
  logic               from_start_s;
  logic [SEL_W-1:0]   nxt_ch_s;
  logic               wrap_s;
  logic               none_s;
  logic               go_s;
  logic               valid_nxt_s;
  logic               done_nxt_s;
  logic               busy_nxt_s;

  // Single shared search: live mask from IDLE, latched mask while running.
  always_comb begin
    from_start_s  = (state_r == ST_IDLE);
    search_mask_s = from_start_s ? bus.ch_mask : mask_r;
    go_s          = from_start_s && bus.start && !bus.stop && !none_s;
  end

  find_next_ch u_find (
    .mask       (search_mask_s),
    .cur        (sel_r),
    .from_start (from_start_s),
    .nxt        (nxt_ch_s),
    .wrap       (wrap_s),
    .none       (none_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; stop overrides everything while running.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = go_s ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: begin
        if (bus.stop) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == '0) begin
          state_nxt_s = ST_BLANK;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_BLANK: begin
        if (bus.stop || (wrap_s && one_shot_r)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode, computed one cycle ahead so the outputs are flops.
  // The search result seen in the last ACTIVE cycle equals the one in the
  // following BLANK (same channel, same latched mask), so wrap is valid here.
  always_comb begin
    valid_nxt_s = (state_nxt_s == ST_ACTIVE);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    done_nxt_s  = (state_r == ST_ACTIVE) && (state_nxt_s == ST_BLANK) && wrap_s;
  end

  // Datapath: parameter latch on start, channel/counter load and countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      dwell_r    <= '0;
      mask_r     <= '0;
      one_shot_r <= 1'b0;
      sel_r      <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            mask_r     <= bus.ch_mask;
            dwell_r    <= bus.dwell;
            one_shot_r <= bus.one_shot;
            sel_r      <= nxt_ch_s;
            cnt_r      <= bus.dwell;
          end
        end
        ST_ACTIVE: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - DWELL_W'(1);
          end
        end
        ST_BLANK: begin
          if (state_nxt_s == ST_ACTIVE) begin
            sel_r <= nxt_ch_s;
            cnt_r <= dwell_r;
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Output status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      sel_valid_r  <= valid_nxt_s;
      frame_done_r <= done_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign bus.sel_x      = sel_r[0];
  assign bus.sel_y      = sel_r[1];
  assign bus.sel_z      = sel_r[2];
  assign bus.sel_valid  = sel_valid_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl
//   Self-checking bench for decoder_scan_ctrl. Every cycle the expected
//   {sel[2:0], sel_valid, frame_done, busy} is pushed to a scoreboard queue
//   as the inputs are driven, then popped and compared #1 after the edge.
module tb_decoder_scan_ctrl;
  import decoder_scan_ctrl_pkg::*;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       one_shot;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       valid;
    logic       done;
    logic       busy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [5:0] exp_q[$];
  vec_t tbl [0:7];

  decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ex(input int sel, input logic v, input logic d, input logic b);
    logic [2:0] s;
    s = 3'(sel);
    return {s, v, d, b};
  endfunction

  task automatic check(input string tag);
    logic [5:0] got;
    logic [5:0] want;
    got  = {bus.sel_z, bus.sel_y, bus.sel_x, bus.sel_valid, bus.frame_done, bus.busy};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got sel=%0d valid=%b done=%b busy=%b, expected sel=%0d valid=%b done=%b busy=%b",
               tag, $time, got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic os,
                      input logic [7:0] dw, input logic [7:0] msk,
                      input logic [5:0] want, input string tag);
    bus.start    = st;
    bus.stop     = sp;
    bus.one_shot = os;
    bus.dwell    = dw;
    bus.ch_mask  = msk;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  // Full-mask run after the start edge: cycle t sits at position t%(dw+2)
  // of channel (t/(dw+2))%8; the last position is the blank. Inputs are
  // deliberately scrambled to show they are ignored mid-run.
  task automatic run_full(input int t_last, input int dw, input string tag);
    int per;
    int pos;
    int ch;
    per = dw + 2;
    for (int t = 1; t <= t_last; t++) begin
      pos = t % per;
      ch  = (t / per) % 8;
      step(1'b0, 1'b0, 1'b1, 8'd0, 8'h0F,
           ex(ch, pos <= dw, (pos == dw + 1) && (ch == 7), 1'b1), tag);
    end
  endtask

  initial begin
    int pos;
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.one_shot = 1'b0;
    bus.dwell = 8'd0;
    bus.ch_mask = 8'h00;

    // Sparse one-shot, start+stop in IDLE, all while sel starts at 1.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'd0, 8'h24, 3'd2, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 8'd9, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd9, 8'hFF, 3'd5, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 3'd5, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'd0, 8'h24, 3'd5, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'hFF, 3'd5, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'hFF, 3'd5, 1'b0, 1'b0, 1'b0};

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd2, 8'hFF, ex(0, 1'b0, 1'b0, 1'b0), "reset_hold");
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd2, 8'hFF, ex(0, 1'b0, 1'b0, 1'b0), "post_reset");

    // Full mask, dwell 2, continuous: two frames plus restart, then stop in BLANK.
    step(1'b1, 1'b0, 1'b0, 8'd2, 8'hFF, ex(0, 1'b1, 1'b0, 1'b1), "full_start");
    run_full(71, 2, "full_dw2");
    step(1'b0, 1'b1, 1'b0, 8'd2, 8'hFF, ex(1, 1'b0, 1'b0, 1'b0), "stop_in_blank");

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].one_shot, tbl[i].dwell, tbl[i].mask,
           {tbl[i].sel, tbl[i].valid, tbl[i].done, tbl[i].busy}, $sformatf("table%0d", i));
    end

    // Empty mask never starts.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd3, 8'h00, ex(5, 1'b0, 1'b0, 1'b0), "empty_mask");
    end

    // Stop in the second ACTIVE cycle of channel 3 (dwell 5).
    step(1'b1, 1'b0, 1'b0, 8'd5, 8'hFF, ex(0, 1'b1, 1'b0, 1'b1), "stop_run_start");
    run_full(22, 5, "full_dw5");
    step(1'b0, 1'b1, 1'b0, 8'd5, 8'hFF, ex(3, 1'b0, 1'b0, 1'b0), "stop_active");
    step(1'b0, 1'b0, 1'b0, 8'd5, 8'hFF, ex(3, 1'b0, 1'b0, 1'b0), "after_stop");

    // Single channel 7, dwell 1; start pulse and mask change mid-run ignored.
    step(1'b1, 1'b0, 1'b0, 8'd1, 8'h80, ex(7, 1'b1, 1'b0, 1'b1), "single_start");
    for (int t = 1; t <= 17; t++) begin
      pos = t % 3;
      step(t == 5, 1'b0, 1'b0, 8'd0, 8'h01, ex(7, pos < 2, pos == 2, 1'b1), "single_ch");
    end
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'h01, ex(7, 1'b0, 1'b0, 1'b0), "single_stop");

    // Asynchronous reset while channel 4 is active.
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'hFF, ex(0, 1'b1, 1'b0, 1'b1), "rst_run_start");
    run_full(21, 3, "full_dw3");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(ex(0, 1'b0, 1'b0, 1'b0));
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd3, 8'hFF, ex(0, 1'b0, 1'b0, 1'b0), "after_async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
